// File: rtl/priority_enc_if.sv
// rtl/priority_enc_if.sv - request/result bundle for priority_enc; mask signal present only with PRIORITYENC_MASK_EN.
interface priority_enc_if #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH)
);
  logic             en;
  logic [WIDTH-1:0] in;
`ifdef PRIORITYENC_MASK_EN
  logic [WIDTH-1:0] mask;
`endif
  logic [OUT_W-1:0] out;
  logic [WIDTH-1:0] onehot;
  logic             valid;

`ifdef PRIORITYENC_MASK_EN
  modport master (output en, in, mask, input out, onehot, valid);
  modport slave  (input en, in, mask, output out, onehot, valid);
`else
  modport master (output en, in, input out, onehot, valid);
  modport slave  (input en, in, output out, onehot, valid);
`endif
endinterface

// File: rtl/priority_enc.sv
// rtl/priority_enc.sv - registered highest-index-wins priority encoder; optional request mask via PRIORITYENC_MASK_EN.
module priority_enc #(
  parameter int WIDTH = 8,
  parameter int OUT_W = $clog2(WIDTH)
) (
  input  logic           clk,
  input  logic           rst,
  priority_enc_if.slave  bus
);

  logic [WIDTH-1:0] eff;
  logic [OUT_W-1:0] win_idx;

  logic [OUT_W-1:0] out_d, out_q;
  logic [WIDTH-1:0] onehot_d, onehot_q;
  logic             valid_d, valid_q;

`ifdef PRIORITYENC_MASK_EN
  assign eff = bus.in & bus.mask;
`else
  assign eff = bus.in;
`endif

  // Ascending scan: the last set bit seen is the highest, so it overrides lower ones.
  // The index only ever takes values 0..WIDTH-1, even for non-power-of-two widths.
  always_comb begin
    win_idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (eff[i]) begin
        win_idx = OUT_W'(i);
      end
    end
  end

  always_comb begin
    valid_d  = |eff;
    out_d    = win_idx;
    onehot_d = valid_d ? (WIDTH'(1) << win_idx) : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q    <= '0;
      onehot_q <= '0;
      valid_q  <= 1'b0;
    end else if (bus.en) begin
      out_q    <= out_d;
      onehot_q <= onehot_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.out    = out_q;
  assign bus.onehot = onehot_q;
  assign bus.valid  = valid_q;

endmodule

// File: tb/tb_priority_enc.sv
// tb/tb_priority_enc.sv - scoreboard bench for priority_enc (WIDTH=8), mask cases when PRIORITYENC_MASK_EN is defined.
module tb_priority_enc;

  typedef struct packed {
    logic [2:0] out;
    logic [7:0] oh;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [7:0] tb_mask = 8'hFF;
  int tests = 0;
  int fails = 0;
  exp_t sb[$];
  exp_t m_state = '0;

  priority_enc_if #(.WIDTH(8)) bus ();

`ifdef PRIORITYENC_MASK_EN
  assign bus.mask = tb_mask;
`endif

  priority_enc #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] v, input logic [7:0] m);
    logic [7:0] e;
    exp_t r;
    e = v & m;
    r = '0;
    for (int i = 7; i >= 0; i--) begin
      if (e[i]) begin
        r.out = 3'(i);
        r.oh  = 8'b1 << i;
        r.v   = 1'b1;
        break;
      end
    end
    return r;
  endfunction

  function automatic exp_t observed();
    exp_t g;
    g.out = bus.out;
    g.oh  = bus.onehot;
    g.v   = bus.valid;
    return g;
  endfunction

  task automatic drive(input logic e, input logic [7:0] v, input logic [7:0] m);
    @(negedge clk);
    bus.en  = e;
    bus.in  = v;
    tb_mask = m;
    if (e) m_state = model(v, m);
    sb.push_back(m_state);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    exp_t g, e;
    bus.en = 1'b1;
    bus.in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    g = observed();
    tests++;
    if (g !== exp_t'(0)) begin
      fails++;
      $display("FAIL reset_held got=%b required=%b", g, exp_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1'b1, 8'b0100_0000, 8'hFF);
    g = observed();
    e = sb.pop_front();
    tests++;
    if (g !== e || g !== exp_t'({3'b110, 8'b0100_0000, 1'b1})) begin
      fails++;
      $display("FAIL reset_first_capture got=%b required=%b", g, e);
    end
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    g = observed();
    tests++;
    if (g !== exp_t'(0)) begin
      fails++;
      $display("FAIL reset_async got=%b required=%b", g, exp_t'(0));
    end
    @(posedge clk);
    #1;
    g = observed();
    tests++;
    if (g !== exp_t'(0)) begin
      fails++;
      $display("FAIL reset_edge_ignored got=%b required=%b", g, exp_t'(0));
    end
    @(negedge clk);
    rst = 1'b0;
    m_state = '0;
  endtask

  task automatic test_single();
    logic [7:0] vec [2] = '{8'b1000_0000, 8'b0000_0001};
    exp_t g, e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, vec[i], 8'hFF);
      g = observed();
      e = sb.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL single[%0d] got=%b required=%b", i, g, e);
      end
    end
  endtask

  task automatic test_multiple();
    logic [7:0] vec [3] = '{8'b1010_1010, 8'b0001_1100, 8'b0000_0011};
    exp_t g, e;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vec[i], 8'hFF);
      g = observed();
      e = sb.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL multiple[%0d] got=%b required=%b", i, g, e);
      end
    end
  endtask

  task automatic test_none();
    exp_t g, e;
    drive(1'b1, 8'b0000_0000, 8'hFF);
    g = observed();
    e = sb.pop_front();
    tests++;
    if (g !== e || g.v !== 1'b0) begin
      fails++;
      $display("FAIL none got=%b required=%b", g, e);
    end
  endtask

  task automatic test_enable_hold();
    exp_t g, e;
    drive(1'b1, 8'b0001_1100, 8'hFF);
    g = observed();
    e = sb.pop_front();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL hold_capture got=%b required=%b", g, e);
    end
    #2 bus.in = 8'b1111_0000;
    #1;
    g = observed();
    tests++;
    if (g !== e) begin
      fails++;
      $display("FAIL hold_between_edges got=%b required=%b", g, e);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'b1000_0000, 8'hFF);
      g = observed();
      e = sb.pop_front();
      tests++;
      if (g !== e || g.out !== 3'b100) begin
        fails++;
        $display("FAIL hold_en_low[%0d] got=%b required=%b", i, g, e);
      end
    end
    drive(1'b1, 8'b1000_0000, 8'hFF);
    g = observed();
    e = sb.pop_front();
    tests++;
    if (g !== e || g.out !== 3'b111) begin
      fails++;
      $display("FAIL hold_release got=%b required=%b", g, e);
    end
  endtask

`ifdef PRIORITYENC_MASK_EN
  task automatic test_mask();
    logic [7:0] msk [2] = '{8'b0111_1111, 8'b0101_0101};
    exp_t g, e;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 8'b1010_1010, msk[i]);
      g = observed();
      e = sb.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL mask[%0d] got=%b required=%b", i, g, e);
      end
    end
  endtask
`endif

  task automatic test_back_to_back();
    exp_t g, e;
    logic [7:0] m;
    for (int i = 0; i < 60; i++) begin
`ifdef PRIORITYENC_MASK_EN
      m = 8'($urandom);
`else
      m = 8'hFF;
`endif
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom) >> $urandom_range(0, 7), m);
      g = observed();
      e = sb.pop_front();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL back_to_back[%0d] got=%b required=%b", i, g, e);
      end
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.in = 8'h00;
    test_reset();
    test_single();
    test_multiple();
    test_none();
    test_enable_hold();
`ifdef PRIORITYENC_MASK_EN
    test_mask();
`endif
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
